// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract engine:
//     - FSM state encoding used by serial_adder_ctrl
//     - default operand width
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  // Default operand/result width of the serial engine.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. ST_DONE lasts exactly one cycle and doubles as the
  // done-pulse cycle; a start seen there chains straight into ST_RUN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder, purely combinational.
//   Ports:
//     A, B  : input  operand bits
//     Cin   : input  carry in
//     S     : output sum bit       (A ^ B ^ Cin)
//     Cout  : output carry out     (majority of A, B, Cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic half_sum;

  assign half_sum = A ^ B;
  assign S        = half_sum ^ Cin;
  assign Cout     = (A & B) | (Cin & half_sum);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract engine. One shared full_adder is sequenced over
//   WIDTH clock cycles, LSB first. Operands are captured on an accepted start;
//   the result is published together with a one-cycle done pulse.
//
//   Parameters:
//     WIDTH : operand/result width (>= 2)
//     CNT_W : bit-counter width, derived from WIDTH
//
//   Ports:
//     clk   : input  system clock, rising edge
//     rst   : input  synchronous active-high reset
//     start : input  request pulse, honoured only in IDLE or DONE
//     SUB   : input  0 = A+B+Cin, 1 = A-B (Cin ignored)
//     A, B  : input  operands, captured on accepted start
//     Cin   : input  carry in for add mode
//     busy  : output high while the serial operation runs
//     done  : output one-cycle pulse when S/Cout/V are updated
//     S     : output result, held between completions
//     Cout  : output final carry (SUB: 1 = no borrow)
//     V     : output signed overflow
//
//   Latency: start sampled at edge t, done high in the cycle after edge
//   t+WIDTH (WIDTH+1 cycles start-to-done).
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  // Datapath: the single shared adder slice.
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] r_sh_d;

  full_adder u_full_adder (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // Sum bits enter at the MSB so that after WIDTH shifts the LSB-first
  // stream lines up as a normal binary word.
  assign r_sh_d = {fa_sum, r_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      // done is a pulse: only the RUN->DONE transition raises it.
      done <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and force the carry in.
            a_sh_q  <= A;
            b_sh_q  <= SUB ? ~B : B;
            carry_q <= SUB ? 1'b1 : Cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          r_sh_q  <= r_sh_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CNT_ONE;

          if (last_bit) begin
            // On the MSB slice carry_q is the carry into the MSB, so the
            // signed overflow falls out without a separate stored flag.
            S       <= r_sh_d;
            Cout    <= fa_cout;
            V       <= carry_q ^ fa_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). Stimulus pushes the
//   hand-computed result into a queue; a monitor pops and compares on every
//   done pulse.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             SUB = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  res_t exp_q[$];
  res_t mon_exp;
  res_t mon_act;
  int   n_vec = 0;
  int   n_err = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .V     (V)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      mon_act = {S, Cout, V};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got S=%h Cout=%b V=%b, required no done pulse",
                 S, Cout, V);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL result: got S=%h Cout=%b V=%b, required S=%h Cout=%b V=%b",
                   mon_act.s, mon_act.c, mon_act.v, mon_exp.s, mon_exp.c, mon_exp.v);
        end else begin
          $display("result S=%h Cout=%b V=%b matches", mon_act.s, mon_act.c, mon_act.v);
        end
      end
    end
  end

  // Issue one request; returns at the first negedge after the accepting edge.
  // Inputs are scrambled after acceptance to show they are no longer used.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input logic expect_done,
                        input logic [WIDTH-1:0] es, input logic ec, input logic ev);
    @(negedge clk);
    A = a; B = b; Cin = ci; SUB = sb; start = 1'b1;
    if (expect_done) exp_q.push_back({es, ec, ev});
    $display("issue A=%h B=%h Cin=%b SUB=%b", a, b, ci, sb);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~ci; SUB = ~sb;
    chk("busy_after_start", busy, 1);
  endtask

  // Wait (bounded) for done. lat0 is the negedge index already reached,
  // counting the first negedge after the accepting edge as 1.
  task automatic wait_done(input string name, input int lat0);
    int lat    = lat0;
    int busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, WIDTH + 1);
    chk({name, "_busy_cycles"}, busy_n, WIDTH + 1 - lat0);
    chk({name, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    int done_seen;

    // 1. Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 8'h00);
    chk("rst_Cout", Cout, 0);
    chk("rst_V", V, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // 2. Add
    launch(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
    wait_done("add", 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("idle_after_done_busy", busy, 0);
    chk("S_held_after_done", S, 8'h96);

    // 3. Add with wrap / signed overflow
    launch(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_done("add_wrap", 1);
    launch(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    wait_done("add_cin", 1);

    // 4. Subtract (Cin must be ignored)
    launch(8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    wait_done("sub_borrow", 1);
    launch(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    wait_done("sub_ovf", 1);

    // 5. Handshake: start while busy is ignored, start in DONE is accepted
    launch(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'hAA; B = 8'h55; SUB = 1'b0; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 5);
    A = 8'h04; B = 8'h04; Cin = 1'b0; SUB = 1'b0; start = 1'b1;
    exp_q.push_back({8'h08, 1'b0, 1'b0});
    $display("issue A=04 B=04 Cin=0 SUB=0 during done cycle");
    @(negedge clk);
    start = 1'b0;
    A = 8'hFF; B = 8'hFF;
    chk("chain_busy", busy, 1);
    chk("chain_done_low", done, 0);
    chk("chain_S_hold_early", S, 8'h03);
    repeat (4) @(negedge clk);
    chk("chain_S_hold_mid", S, 8'h03);
    wait_done("chain", 5);

    // 6. Reset mid-operation
    launch(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_S", S, 8'h00);
    chk("abort_Cout", Cout, 0);
    chk("abort_V", V, 0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    launch(8'h22, 8'h11, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    wait_done("after_abort", 1);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine that sequences one shared 1-bit `full_adder` instance over WIDTH cycles.
- Operands are captured on a start pulse and processed LSB-first, one bit per clock.
- Result, carry-out and signed overflow are presented with a one-cycle done pulse.
- Trades area for latency: it replaces a WIDTH-bit ripple adder wherever throughput is not critical.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is idle or done.
- SUB  input  1  0 = A+B+Cin; 1 = A-B (B inverted, carry-in forced 1, Cin ignored).
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- Cin  input  1  carry-in for add mode; captured on an accepted start.
- busy  output  1  high while serial operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- S  output  WIDTH  result; held stable between completions.
- Cout  output  1  final carry out; in SUB mode, 1 = no borrow.
- V  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, busy=0, done=0, S=0, Cout=0, V=0.
  - Internal shift registers, carry flop and counter are all cleared.
- States and transitions:
  - IDLE --start--> RUN
  - RUN --(count==WIDTH-1)--> DONE
  - DONE --start--> RUN
  - DONE --!start--> IDLE
- Accepted start (state IDLE or DONE):
  - Load a_sh=A and b_sh = SUB ? ~B : B.
  - Load carry = SUB ? 1 : Cin, count=0, busy=1.
- RUN, each cycle:
  - Drive the full_adder with a_sh[0], b_sh[0] and carry.
  - Shift its sum bit into the MSB of r_sh (right shift).
  - Shift a_sh and b_sh right; carry <= adder Cout; count <= count+1.
  - On the last bit (count==WIDTH-1), also record cmsb = carry in use for that bit.
- Transition to DONE (edge ending the last RUN cycle):
  - S <= final r_sh, Cout <= adder Cout, V <= cmsb ^ adder Cout.
  - busy=0, done=1 for exactly the DONE cycle.
- Latency: start sampled at edge t; done high in the cycle after edge t+WIDTH. That is WIDTH+1 cycles start-to-done, and back-to-back throughput is one op per WIDTH+1 cycles.
- Output stability: S, Cout and V change only on a DONE entry or on reset; partial sums are never visible on the outputs.
- start while busy=1: ignored; the operation in flight is unaffected and no request is queued.
- start during the DONE cycle: accepted; done still pulses for the current result and busy rises on the next cycle.
- A, B, Cin and SUB changing after acceptance: no effect.
- Reset mid-RUN: the operation is aborted, no done pulse is produced and outputs return to 0.
- Arithmetic wraps modulo 2^WIDTH; Cout and V report the wrap.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - the default WIDTH constant.
- One sub-module: the existing `full_adder` (ports A, B, Cin, S, Cout), instantiated once as the serial datapath.
- FSM, shift registers and counter live in serial_adder_ctrl.

Test Plan (WIDTH=8):
1. Reset: hold rst 2 cycles -> busy=0, done=0, S=8'h00, Cout=0, V=0; start held 0 keeps the block idle.
2. Add: A=8'h5A, B=8'h3C, Cin=0, SUB=0, start at edge t -> busy=1 for 8 cycles; done pulses one cycle after edge t+8; S=8'h96, Cout=0, V=1.
3. Add wrap: A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, V=0. Then A=8'h7F, B=8'h00, Cin=1 -> S=8'h80, Cout=0, V=1.
4. Subtract: SUB=1, A=8'h10, B=8'h20, Cin=1 (must be ignored) -> S=8'hF0, Cout=0, V=0. Then A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, V=1.
5. Handshake: during an op (A=8'h01, B=8'h02), pulse start with A=8'hAA at RUN cycle 3 -> ignored, result S=8'h03. Then assert start in the DONE cycle with A=8'h04, B=8'h04 -> busy rises next cycle, second done gives S=8'h08, and S holds 8'h03 until then.
6. Reset mid-op: start A=8'hF0, B=8'h0F; assert rst at RUN cycle 4 -> no done pulse, busy=0, S=0. A following op A=8'h22, B=8'h11 -> S=8'h33, Cout=0, V=0.
